display_scan: RTL and testbench

Time-multiplexed scan controller for the 8-digit seven-segment display. Sits directly upstream of the per-digit BCD-to-segment decoder and drives its `x` input together with the board anode lines `an`. Each cycle it presents one digit's BCD nibble and one active-low anode. It adds per-digit blanking, a blink overlay, and an anode dead time so that a changing nibble never ghosts onto the next digit.

---
 rtl/display_pkg.sv | 11 +
 rtl/scan_prescaler.sv | 29 ++
 rtl/display_scan.sv | 81 ++++++++
 tb/tb_display_scan.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared constants and types for the seven-segment scan logic.
//   NUM_DIGITS  - digits on the display
//   ANODE_OFF   - anode pattern with every digit dark (anodes are active-low)
//   digit_idx_t - digit slot index
//   bcd_t       - one BCD nibble
package display_pkg;
   localparam int         NUM_DIGITS = 8;
   localparam logic [7:0] ANODE_OFF  = 8'hFF;
   typedef logic [2:0] digit_idx_t;
   typedef logic [3:0] bcd_t;
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: divides clk into digit slots of PRESCALE cycles.
//   clk, rst_n - clock, synchronous active-low reset
//   load_stb   - high on the cycle whose closing edge ends the dead time
//   slot_end   - high on the last cycle of the slot
module scan_prescaler #(
   parameter int PRESCALE    = 100_000,
   parameter int DEAD_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic load_stb,
   output logic slot_end
);
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST    = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] LOAD_AT = CW'(DEAD_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)          cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
   end

   // Strobes flag the cycle before the edge on which the top acts.
   assign load_stb = (cnt == LOAD_AT);
   assign slot_end = (cnt == LAST);
endmodule

// File: rtl/display_scan.sv
// display_scan: 8-digit seven-segment scan controller with blanking, blink
// and an anode dead time at the start of every slot.
//   clk, rst_n  - clock, synchronous active-low reset
//   digits      - eight BCD nibbles, digit 0 rightmost
//   blank_mask  - 1 = digit always dark
//   blink_mask  - 1 = digit dark while blink_phase is 1
//   x           - nibble to the segment decoder
//   an          - active-low anodes, at most one low
//   frame_tick  - one-cycle pulse when the scan wraps back to digit 0
//   blink_phase - 1 = blinking digits dark
module display_scan
   import display_pkg::*;
#(
   parameter int PRESCALE     = 100_000,
   parameter int DEAD_CYCLES  = 4,
   parameter int BLINK_FRAMES = 250
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] digits,
   input  logic [7:0]  blank_mask,
   input  logic [7:0]  blink_mask,
   output logic [3:0]  x,
   output logic [7:0]  an,
   output logic        frame_tick,
   output logic        blink_phase
);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
   localparam digit_idx_t    IDX_LAST = digit_idx_t'(NUM_DIGITS - 1);

   logic          load_stb, slot_end;
   digit_idx_t    idx;
   logic [FW-1:0] frm;
   logic          vis;
   bcd_t          nib;

   scan_prescaler #(
      .PRESCALE    (PRESCALE),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_pre (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_stb (load_stb),
      .slot_end (slot_end)
   );

   assign nib = digits[4*idx +: 4];
   assign vis = ~blank_mask[idx] & ~(blink_mask[idx] & blink_phase);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx         <= '0;
         frm         <= '0;
         blink_phase <= 1'b0;
         x           <= 4'h0;
         an          <= ANODE_OFF;
         frame_tick  <= 1'b0;
      end else begin
         frame_tick <= slot_end && (idx == IDX_LAST);
         // x only moves here, after the dead time has kept every anode off,
         // so a new nibble never appears on a lit digit.
         if (load_stb) begin
            x  <= nib;
            an <= vis ? ~(8'b1 << idx) : ANODE_OFF;
         end
         if (slot_end) begin
            an  <= ANODE_OFF;
            idx <= idx + 3'd1;
            if (idx == IDX_LAST) begin
               if (frm == FRM_LAST) begin
                  frm         <= '0;
                  blink_phase <= ~blink_phase;
               end else begin
                  frm <= frm + 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] digits;
   logic [7:0]  blank_mask, blink_mask;
   logic [3:0]  x;
   logic [7:0]  an;
   logic        frame_tick, blink_phase;

   display_scan #(.PRESCALE(4), .DEAD_CYCLES(1), .BLINK_FRAMES(2)) dut (
      .clk(clk), .rst_n(rst_n), .digits(digits), .blank_mask(blank_mask),
      .blink_mask(blink_mask), .x(x), .an(an), .frame_tick(frame_tick),
      .blink_phase(blink_phase)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] x;
      logic [7:0] an;
      logic       ft;
      logic       bp;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   logic rst_q = 1'b0;
   int   checks = 0, errors = 0;
   logic done = 1'b0;
   logic [3:0] x_prev = 4'h0;
   logic [7:0] an_prev = 8'hFF;

   // cyc = number of rising edges so far; rst_q = rst_n seen by the last edge
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst_n;
   end

   task automatic push(input int c, input logic [3:0] ex, input logic [7:0] ean,
                       input logic ft, input logic bp);
      exp_t e;
      e.cyc = c; e.x = ex; e.an = ean; e.ft = ft; e.bp = bp;
      q.push_back(e);
   endtask

   // s = load edge; three lit cycles then the slot-end edge with anodes off
   task automatic push_slot(input int s, input logic [3:0] ex, input logic [7:0] ean,
                            input logic ft_end, input logic bp, input logic bp_end);
      for (int i = 0; i < 3; i++) push(s + i, ex, ean, 1'b0, bp);
      push(s + 3, ex, 8'hFF, ft_end, bp_end);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Monitor: pops expectations due this cycle, plus the anti-ghost check.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (e.cyc < cyc) begin
            errors++;
            $display("FAIL missed_cycle_%0d at cycle %0d", e.cyc, cyc);
         end else if (x !== e.x || an !== e.an || frame_tick !== e.ft || blink_phase !== e.bp) begin
            errors++;
            $display("FAIL cycle_%0d got x=%h an=%h ft=%b bp=%b want x=%h an=%h ft=%b bp=%b",
                     cyc, x, an, frame_tick, blink_phase, e.x, e.an, e.ft, e.bp);
         end
      end
      if (rst_q && x !== x_prev) begin
         checks++;
         if (an_prev !== 8'hFF) begin
            errors++;
            $display("FAIL ghost cycle_%0d x %h->%h with an_prev=%h want an_prev=ff",
                     cyc, x_prev, x, an_prev);
         end
      end
      x_prev  = x;
      an_prev = an;
      if (done) begin
         checks++;
         if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got %0d want 0", q.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int         r, r2;
      logic [7:0] one;
      logic [3:0] ex;
      logic [7:0] ean;
      logic       bp, bp_end;
      one        = 8'b1;
      rst_n      = 1'b0;
      digits     = 32'h8765_4321;
      blank_mask = 8'h00;
      blink_mask = 8'h00;

      // reset state while held
      push(2, 4'h0, 8'hFF, 1'b0, 1'b0);
      push(3, 4'h0, 8'hFF, 1'b0, 1'b0);
      wait_cyc(3);
      rst_n = 1'b1;
      r = 3;

      // Frames 0..3 in full, frame 4 up to the mid-slot reset in digit 5.
      // f0: plain; f1: digit 2 blanked, digit 0 changes to 9 mid-slot;
      // f2,f3: blink phase 1 darkens digit 0 too; f4: masks cleared.
      for (int f = 0; f <= 4; f++) begin
         bp = (f == 2 || f == 3);
         for (int k = 0; k < 8; k++) begin
            int s;
            s  = r + 1 + 32*f + 4*k;
            ex = (k == 0) ? ((f >= 2) ? 4'h9 : 4'h1) : 4'(k + 1);
            ean = ~(one << k);
            if (f >= 1 && f <= 3 && k == 2) ean = 8'hFF;
            if (f >= 2 && f <= 3 && k == 0) ean = 8'hFF;
            bp_end = (k == 7) ? (f == 1 || f == 2) : bp;
            if (f == 4 && k == 5) begin
               push(s, ex, ean, 1'b0, 1'b0);
               push(s + 1, ex, ean, 1'b0, 1'b0);
               push(s + 2, 4'h0, 8'hFF, 1'b0, 1'b0);
               break;
            end
            push_slot(s, ex, ean, k == 7, bp, bp_end);
         end
      end

      wait_cyc(r + 32);
      blank_mask = 8'h04;
      blink_mask = 8'h01;
      wait_cyc(r + 34);              // digit 0 lit in frame 1
      digits = 32'h8765_4329;
      wait_cyc(r + 128);
      blank_mask = 8'h00;
      blink_mask = 8'h00;
      wait_cyc(r + 150);             // digit 5 lit in frame 4
      rst_n = 1'b0;
      wait_cyc(r + 151);
      rst_n = 1'b1;
      r2 = r + 151;
      push_slot(r2 + 1, 4'h9, 8'hFE, 1'b0, 1'b0, 1'b0);
      push_slot(r2 + 5, 4'h2, 8'hFD, 1'b0, 1'b0, 1'b0);
      wait_cyc(r2 + 9);
      done = 1'b1;
   end
endmodule
